// File: rtl/dbus_mmio_bridge.sv
// Data-bus bridge: routes core accesses to the RAM data port, a small MMIO block
// (timer, scratch, console TX FIFO) or an error response; one access in flight.
module dbus_mmio_bridge #(
  parameter int MEM_AW     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dBus_cmd_valid,
  output logic              dBus_cmd_ready,
  input  logic [31:0]       dBus_cmd_payload_addr,
  input  logic [31:0]       dBus_cmd_payload_data,
  input  logic [3:0]        dBus_cmd_payload_size,
  input  logic              dBus_cmd_payload_wr,
  output logic              dBus_rsp_valid,
  output logic [31:0]       dBus_rsp_data,
  output logic              dBus_rsp_error,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [31:0]       m_data,
  output logic [3:0]        m_mask,
  input  logic              m_rsp_valid,
  input  logic [31:0]       m_rsp_data,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MEM_REQ  = 3'd1;
  localparam logic [2:0] MEM_WAIT = 3'd2;
  localparam logic [2:0] MMIO     = 3'd3;
  localparam logic [2:0] RSP      = 3'd4;

  localparam logic [1:0] REG_TIMER    = 2'd0;
  localparam logic [1:0] REG_SCRATCH  = 2'd1;
  localparam logic [1:0] REG_CON_TX   = 2'd2;
  localparam logic [1:0] REG_CON_STAT = 2'd3;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h1;

  logic [2:0]        stateReg, stateNext;
  logic [MEM_AW-1:0] addrReg;
  logic [31:0]       dataReg;
  logic [3:0]        maskReg;
  logic              wrReg;
  logic [31:0]       rspDataReg;
  logic              rspErrorReg;
  logic [31:0]       timerReg;
  logic [31:0]       scratchReg, scratchNext;
  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtrReg, rdPtrReg;
  logic [PTR_W:0]    countReg;

  logic        cmdFire;
  logic [3:0]  cmdRegion;
  logic [1:0]  mmioOff;
  logic        fifoFull, fifoEmpty;
  logic        popFire, pushFire, conTxWrite, scratchWe;
  logic [31:0] mmioReadData;
  logic        unusedAddr;

  // Upper address bits only matter through the region decode.
  assign unusedAddr = ^dBus_cmd_payload_addr;

  assign dBus_cmd_ready = (stateReg == IDLE) && !rst;
  assign cmdFire        = dBus_cmd_valid && dBus_cmd_ready;
  assign cmdRegion      = dBus_cmd_payload_addr[31:28];
  assign mmioOff        = addrReg[3:2];

  assign fifoFull   = (countReg == FULL_COUNT);
  assign fifoEmpty  = (countReg == '0);
  assign popFire    = !fifoEmpty && con_ready;
  assign conTxWrite = (stateReg == MMIO) && wrReg && (mmioOff == REG_CON_TX);
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign pushFire   = conTxWrite && (!fifoFull || popFire);
  assign scratchWe  = (stateReg == MMIO) && wrReg && (mmioOff == REG_SCRATCH);

  assign dBus_rsp_valid = (stateReg == RSP);
  assign dBus_rsp_data  = rspDataReg;
  assign dBus_rsp_error = rspErrorReg;

  assign m_valid = (stateReg == MEM_REQ);
  assign m_we    = wrReg;
  assign m_addr  = addrReg;
  assign m_data  = dataReg;
  assign m_mask  = maskReg;

  assign con_valid = !fifoEmpty;
  assign con_data  = fifoMem[rdPtrReg];

  for (genvar gi = 0; gi < 4; gi++) begin : gScratchLane
    assign scratchNext[gi*8 +: 8] = (scratchWe && maskReg[gi]) ? dataReg[gi*8 +: 8]
                                                               : scratchReg[gi*8 +: 8];
  end

  always_comb begin
    mmioReadData = 32'd0;
    case (mmioOff)
      REG_TIMER:    mmioReadData = timerReg;
      REG_SCRATCH:  mmioReadData = scratchReg;
      REG_CON_TX:   mmioReadData = 32'd0;
      REG_CON_STAT: mmioReadData = {24'd0, 6'(countReg), fifoEmpty, fifoFull};
      default:      mmioReadData = 32'd0;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (cmdFire) begin
          if (cmdRegion == REGION_RAM)       stateNext = MEM_REQ;
          else if (cmdRegion == REGION_MMIO) stateNext = MMIO;
          else                               stateNext = RSP;
        end
      end
      MEM_REQ:  if (m_ready) stateNext = wrReg ? IDLE : MEM_WAIT;
      MEM_WAIT: if (m_rsp_valid) stateNext = RSP;
      MMIO: begin
        if (!wrReg)                                   stateNext = RSP;
        else if (!conTxWrite || pushFire)             stateNext = IDLE;
      end
      RSP:      stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      addrReg     <= '0;
      dataReg     <= 32'd0;
      maskReg     <= 4'd0;
      wrReg       <= 1'b0;
      rspDataReg  <= 32'd0;
      rspErrorReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (cmdFire) begin
        addrReg <= dBus_cmd_payload_addr[MEM_AW-1:0];
        dataReg <= dBus_cmd_payload_data;
        maskReg <= dBus_cmd_payload_size;
        wrReg   <= dBus_cmd_payload_wr;
      end
      if (cmdFire && cmdRegion != REGION_RAM && cmdRegion != REGION_MMIO) begin
        rspDataReg  <= 32'd0;
        rspErrorReg <= 1'b1;
      end else if (stateReg == MEM_WAIT && m_rsp_valid) begin
        rspDataReg  <= m_rsp_data;
        rspErrorReg <= 1'b0;
      end else if (stateReg == MMIO && !wrReg) begin
        rspDataReg  <= mmioReadData;
        rspErrorReg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timerReg   <= 32'd0;
      scratchReg <= 32'd0;
    end else begin
      timerReg   <= timerReg + 32'd1;
      scratchReg <= scratchNext;
    end
  end

  always_ff @(posedge clk) begin
    if (pushFire) fifoMem[wrPtrReg] <= dataReg[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (pushFire) wrPtrReg <= wrPtrReg + 1'b1;
      if (popFire)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({pushFire, popFire})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_mmio_bridge.sv
// Scoreboard bench for dbus_mmio_bridge: directed accesses push expected
// responses; monitors pop and compare on dBus_rsp_valid and console pops.
module tb_dbus_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dBus_cmd_valid = 1'b0;
  logic        dBus_cmd_ready;
  logic [31:0] dBus_cmd_payload_addr = 32'd0;
  logic [31:0] dBus_cmd_payload_data = 32'd0;
  logic [3:0]  dBus_cmd_payload_size = 4'd0;
  logic        dBus_cmd_payload_wr = 1'b0;
  logic        dBus_rsp_valid;
  logic [31:0] dBus_rsp_data;
  logic        dBus_rsp_error;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_we;
  logic [14:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data = 32'd0;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic [7:0]  con_data;

  always #5 clk = ~clk;

  dbus_mmio_bridge #(.MEM_AW(15), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
    .dBus_cmd_payload_addr(dBus_cmd_payload_addr), .dBus_cmd_payload_data(dBus_cmd_payload_data),
    .dBus_cmd_payload_size(dBus_cmd_payload_size), .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
    .dBus_rsp_valid(dBus_rsp_valid), .dBus_rsp_data(dBus_rsp_data), .dBus_rsp_error(dBus_rsp_error),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .m_mask(m_mask), .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          dueCyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  conExp[$];
  exp_t        monE;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rspSeen = 0;
  logic [31:0] tmod;
  logic [31:0] tOffset = 32'd0;

  // Slave-side bookkeeping
  logic [31:0] mem [int];
  int          mReqCount = 0;
  logic [14:0] lastAddr = '0;
  logic        lastWe = 1'b0;
  logic [31:0] lastData = 32'd0;
  logic [3:0]  lastMask = 4'd0;
  bit          holdRsp = 1'b0;
  int          pulseReq = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tmod <= rst ? 32'd0 : tmod + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end else begin
      $display("ok   %s = %h", nm, got);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (dBus_rsp_valid) begin
      rspSeen++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got data=%h err=%0d", dBus_rsp_data, dBus_rsp_error);
      end else begin
        monE = sbq.pop_front();
        if (dBus_rsp_data !== monE.data || dBus_rsp_error !== monE.err ||
            (monE.dueCyc >= 0 && cyc != monE.dueCyc)) begin
          errors++;
          $display("FAIL %s got data=%h err=%0d cyc=%0d want data=%h err=%0d cyc=%0d",
                   monE.name, dBus_rsp_data, dBus_rsp_error, cyc, monE.data, monE.err, monE.dueCyc);
        end else begin
          $display("ok   %s rsp data=%h err=%0d cyc=%0d", monE.name, dBus_rsp_data, dBus_rsp_error, cyc);
        end
      end
    end
  end

  // Console monitor
  always @(negedge clk) begin
    if (con_valid && con_ready) begin
      checks++;
      if (conExp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_con_byte got=%h", con_data);
      end else if (con_data !== conExp[0]) begin
        errors++;
        $display("FAIL con_byte got=%h want=%h", con_data, conExp[0]);
        void'(conExp.pop_front());
      end else begin
        $display("ok   con_byte %h", con_data);
        void'(conExp.pop_front());
      end
    end
  end

  // RAM slave: ready in the first m_valid cycle, read data two cycles later
  initial begin
    int          rspDelay;
    int          pulseDone;
    logic [31:0] rspData;
    logic [31:0] w;
    rspDelay  = 0;
    pulseDone = 0;
    rspData   = 32'd0;
    forever begin
      tick();
      m_rsp_valid = 1'b0;
      if (rspDelay > 0) begin
        rspDelay--;
        if (rspDelay == 0 && !holdRsp) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = rspData;
        end
      end
      if (pulseReq != pulseDone) begin
        pulseDone   = pulseReq;
        m_rsp_valid = 1'b1;
        m_rsp_data  = 32'hBAD0_BAD0;
      end
      m_ready = m_valid;
      if (m_valid) begin
        mReqCount++;
        lastAddr = m_addr;
        lastWe   = m_we;
        lastData = m_data;
        lastMask = m_mask;
        w = mem.exists(int'(m_addr >> 2)) ? mem[int'(m_addr >> 2)] : 32'd0;
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_mask[b]) w[b*8 +: 8] = m_data[b*8 +: 8];
          mem[int'(m_addr >> 2)] = w;
        end else begin
          rspData  = w;
          rspDelay = 2;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic w, input bit expRsp, input logic [31:0] ed,
                       input logic ee, input int lat, input string nm, input bit useTimer);
    exp_t e;
    int   k;
    tick();
    dBus_cmd_valid        = 1'b1;
    dBus_cmd_payload_addr = a;
    dBus_cmd_payload_data = d;
    dBus_cmd_payload_size = m;
    dBus_cmd_payload_wr   = w;
    k = 0;
    while (!dBus_cmd_ready) begin
      tick();
      k++;
      if (k > 200) begin
        checks++;
        errors++;
        $display("FAIL %s_accept_timeout got=no_ready want=ready", nm);
        dBus_cmd_valid = 1'b0;
        return;
      end
    end
    if (expRsp) begin
      e.data   = useTimer ? (tmod + tOffset + 32'd1) : ed;
      e.err    = ee;
      e.dueCyc = (lat >= 0) ? cyc + lat : -1;
      e.name   = nm;
      sbq.push_back(e);
    end
    $display("cmd  %s addr=%h data=%h mask=%h wr=%0d cyc=%0d", nm, a, d, m, w, cyc);
    tick();
    dBus_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() > 0; k++) tick();
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got pending=%0d want=0", sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  initial begin
    int base;
    int k;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, dBus_cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, dBus_rsp_valid}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_con_valid", {31'd0, con_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // RAM write then read back
    issue(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 32'd0, 1'b0, -1, "ram_wr", 0);
    repeat (3) tick();
    chk("ram_wr_addr", {17'd0, lastAddr}, 32'h0000_0100);
    chk("ram_wr_we", {31'd0, lastWe}, 32'd1);
    chk("ram_wr_data", lastData, 32'hDEAD_BEEF);
    chk("ram_wr_mask", {28'd0, lastMask}, 32'h0000_000F);
    issue(32'h0000_0100, 32'd0, 4'hF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, -1, "ram_rd", 0);
    drain();
    chk("ram_rd_addr", {17'd0, lastAddr}, 32'h0000_0100);
    chk("ram_req_count", mReqCount, 32'd2);

    // SCRATCH, TIMER, CON_TX read
    issue(32'h1000_0004, 32'h1122_3344, 4'h5, 1'b1, 0, 32'd0, 1'b0, -1, "scr_wr", 0);
    issue(32'h1FFF_FFF7, 32'd0, 4'hF, 1'b0, 1, 32'h0022_0044, 1'b0, 2, "scr_rd", 0);
    issue(32'h1000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "timer_rd_a", 1);
    repeat (10) tick();
    issue(32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 32'd0, 1'b0, -1, "timer_wr", 0);
    issue(32'h1000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "timer_rd_b", 1);
    issue(32'h1000_0008, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "contx_rd", 0);
    drain();

    // Console FIFO fill, stall, drain
    con_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h44; b++) begin
      conExp.push_back(8'(b));
      issue(32'h1000_0008, 32'h0000_0000 | b, 4'h0, 1'b1, 0, 32'd0, 1'b0, -1, "con_wr", 0);
    end
    issue(32'h1000_000C, 32'd0, 4'hF, 1'b0, 1, 32'h0000_0011, 1'b0, 2, "stat_full", 0);
    drain();
    chk("con_head", {24'd0, con_data}, 32'h0000_0041);
    conExp.push_back(8'h45);
    issue(32'h1000_0008, 32'h0000_0045, 4'h0, 1'b1, 0, 32'd0, 1'b0, -1, "con_wr5", 0);
    repeat (4) begin
      chk("con_stall_ready", {31'd0, dBus_cmd_ready}, 32'd0);
      tick();
    end
    con_ready = 1'b1;
    k = 0;
    while (!dBus_cmd_ready && k < 50) begin tick(); k++; end
    chk("con_stall_release", {31'd0, dBus_cmd_ready}, 32'd1);
    for (k = 0; k < 50 && conExp.size() > 0; k++) tick();
    chk("con_drained", conExp.size(), 32'd0);
    issue(32'h1000_000C, 32'd0, 4'hF, 1'b0, 1, 32'h0000_0002, 1'b0, 2, "stat_empty", 0);
    drain();

    // Decode errors: no RAM request, no console byte
    base = mReqCount;
    issue(32'h2000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b1, 1, "err_rd", 0);
    issue(32'hF000_0000, 32'h0000_0055, 4'hF, 1'b1, 1, 32'd0, 1'b1, 1, "err_wr", 0);
    drain();
    repeat (3) tick();
    chk("err_no_mreq", mReqCount, base);
    issue(32'h1000_000C, 32'd0, 4'hF, 1'b0, 1, 32'h0000_0002, 1'b0, 2, "stat_after_err", 0);
    drain();

    // Reset in MEM_WAIT aborts; stale RAM response ignored
    con_ready = 1'b0;
    issue(32'h1000_0008, 32'h0000_005A, 4'h0, 1'b1, 0, 32'd0, 1'b0, -1, "con_wr_pre", 0);
    issue(32'h1000_0004, 32'hCAFE_F00D, 4'hF, 1'b1, 0, 32'd0, 1'b0, -1, "scr_wr_pre", 0);
    holdRsp = 1'b1;
    issue(32'h0000_0200, 32'd0, 4'hF, 1'b0, 0, 32'd0, 1'b0, -1, "ram_rd_abort", 0);
    repeat (2) tick();
    chk("abort_in_wait_m_valid", {31'd0, m_valid}, 32'd0);
    base = rspSeen;
    rst = 1'b1;
    tick();
    tick();
    chk("abort_rst_cmd_ready", {31'd0, dBus_cmd_ready}, 32'd0);
    rst = 1'b0;
    pulseReq++;
    repeat (6) tick();
    holdRsp = 1'b0;
    chk("abort_no_rsp", rspSeen, base);
    chk("abort_con_valid", {31'd0, con_valid}, 32'd0);
    issue(32'h1000_000C, 32'd0, 4'hF, 1'b0, 1, 32'h0000_0002, 1'b0, 2, "stat_post_rst", 0);
    issue(32'h1000_0004, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "scr_post_rst", 0);
    issue(32'h1000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "timer_post_rst", 1);
    issue(32'h0000_0100, 32'd0, 4'hF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, -1, "ram_rd_post_rst", 0);
    drain();

    // Timer wrap, preloaded close to the top
    force dut.timerReg = 32'hFFFF_FFFD;
    release dut.timerReg;
    tOffset = 32'hFFFF_FFFD - tmod;
    issue(32'h1000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "timer_wrap_a", 1);
    issue(32'h1000_0000, 32'd0, 4'hF, 1'b0, 1, 32'd0, 1'b0, 2, "timer_wrap_b", 1);
    drain();

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 32'd0);
    chk("con_exp_empty", conExp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
